// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage data-memory access sequencer with stall, timeout and alignment checks
//
// Sequences one load or store at a time over a req/ack memory port. The
// pipeline is held with stall from the first cycle the op is visible until
// the access finishes.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   MEM_R_EN, MEM_W_EN       load / store request from the EXE/MEM register
//   ALU_result, ST_val       byte address and store data
//   mem_req, mem_we          memory request and direction (1 = write)
//   mem_addr, mem_wdata      latched address and store data
//   mem_ack, mem_rdata       memory completion and read data
//   stall                    freeze PC and pipeline registers
//   rd_data, rd_valid        load result and one-cycle "new data" strobe
//   timeout_err, align_err   sticky error flags, cleared only by rst

module mem_access_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic [ADDR_W-1:0] ALU_result,
    input  logic [DATA_W-1:0] ST_val,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              timeout_err,
    output logic              align_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    // The last WAIT cycle index; a WAIT that reaches it without ack abandons
    // the access, so WAIT lasts at most TIMEOUT_CYC cycles.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t              state_q, state_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                timeout_err_q, timeout_err_d;
    logic                align_err_q, align_err_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                op;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            align_err_q   <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            timeout_err_q <= timeout_err_d;
            align_err_q   <= align_err_d;
            cnt_q         <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        rd_data_d     = rd_data_q;
        rd_valid_d    = 1'b0;
        timeout_err_d = timeout_err_q;
        align_err_d   = align_err_q;
        cnt_d         = cnt_q;
        mem_req       = 1'b0;
        stall         = 1'b0;
        op            = MEM_R_EN | MEM_W_EN;

        case (state_q)
            S_IDLE: begin
                // Stall must rise in the same cycle the op appears so the
                // EXE/MEM register does not advance past it.
                stall = op;
                if (op) begin
                    mem_addr_d  = ALU_result;
                    mem_wdata_d = ST_val;
                    mem_we_d    = MEM_W_EN;
                    if (ALU_result[1:0] != 2'b00) begin
                        align_err_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        state_d     = S_REQ;
                    end
                end
            end
            S_REQ: begin
                mem_req = 1'b1;
                stall   = 1'b1;
                cnt_d   = '0;
                if (mem_ack) begin
                    if (!mem_we_q) begin
                        rd_data_d  = mem_rdata;
                        rd_valid_d = 1'b1;
                    end
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                mem_req = 1'b1;
                stall   = 1'b1;
                // Ack is checked first so a response on the final allowed
                // cycle still completes the access.
                if (mem_ack) begin
                    if (!mem_we_q) begin
                        rd_data_d  = mem_rdata;
                        rd_valid_d = 1'b1;
                    end
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_err_d = 1'b1;
                    if (!mem_we_q) begin
                        rd_data_d = '0;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                // Enables still describe the op just finished; ignore them.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign timeout_err = timeout_err_q;
    assign align_err   = align_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl

module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_R_EN, MEM_W_EN;
    logic [31:0] ALU_result, ST_val;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        timeout_err, align_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [31:0] sb[$];

    mem_access_ctrl #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .TIMEOUT_CYC(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MEM_R_EN   (MEM_R_EN),
        .MEM_W_EN   (MEM_W_EN),
        .ALU_result (ALU_result),
        .ST_val     (ST_val),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .stall      (stall),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .timeout_err(timeout_err),
        .align_err  (align_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every rd_valid strobe must match the oldest expected load.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_rd_valid", 1, 0);
            end else begin
                logic [31:0] exp_data;
                exp_data = sb.pop_front();
                check("sb_rd_data", rd_data, exp_data);
            end
        end
    end

    // Drives one op and plays the memory. ack_dly = index of the mem_req cycle
    // that acks (0 = REQ cycle), negative = never. Returns at the DONE cycle.
    task automatic run_op(
        input  bit          r,
        input  bit          w,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  int          ack_dly,
        input  logic [31:0] rdata,
        output int          stall_n,
        output int          req_n,
        output bit          we_ok,
        output bit          addr_ok,
        output bit          wdata_ok,
        output bit          rv_done,
        output int          done_cyc
    );
        bit done;
        @(posedge clk); #1;
        MEM_R_EN   = r;
        MEM_W_EN   = w;
        ALU_result = addr;
        ST_val     = wdata;
        if (r && !w && addr[1:0] == 2'b00 && ack_dly >= 0) sb.push_back(rdata);
        stall_n = 0; req_n = 0; we_ok = 1; addr_ok = 1; wdata_ok = 1;
        rv_done = 0; done_cyc = 0; done = 0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (stall) begin
                stall_n++;
                if (mem_req) begin
                    req_n++;
                    if (mem_we !== w) we_ok = 0;
                    if (mem_addr !== addr) addr_ok = 0;
                    if (mem_wdata !== wdata) wdata_ok = 0;
                    mem_ack   = (ack_dly >= 0 && req_n == ack_dly + 1);
                    mem_rdata = mem_ack ? rdata : 32'hBAD0BAD0;
                end
            end else begin
                done     = 1;
                rv_done  = rd_valid;
                done_cyc = cyc;
                MEM_R_EN = 0;
                MEM_W_EN = 0;
                mem_ack  = 0;
            end
        end
        if (!done) check("op_cycle_bound", 0, 1);
    endtask

    int stall_n, req_n, done_a, done_b;
    bit we_ok, addr_ok, wdata_ok, rv;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; MEM_R_EN = 0; MEM_W_EN = 0; ALU_result = 0; ST_val = 0;
        mem_ack = 0; mem_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_errs", {timeout_err, align_err, rd_valid}, 0);
        rst = 0;

        // Load with immediate ack
        run_op(1, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, stall_n, req_n, we_ok, addr_ok, wdata_ok, rv, done_a);
        check("ld_stall_cycles", stall_n, 2);
        check("ld_req_cycles", req_n, 1);
        check("ld_we_addr_ok", {we_ok, addr_ok}, 2'b11);
        check("ld_rd_valid", rv, 1);
        check("ld_rd_data", rd_data, 32'hDEADBEEF);

        // Store, ack on the last allowed WAIT cycle (ack beats timeout)
        run_op(0, 1, 32'h20, 32'h12345678, 4, 32'h0, stall_n, req_n, we_ok, addr_ok, wdata_ok, rv, done_a);
        check("st_req_cycles", req_n, 5);
        check("st_stall_cycles", stall_n, 6);
        check("st_stable", {we_ok, addr_ok, wdata_ok}, 3'b111);
        check("st_rd_valid", rv, 0);
        check("st_no_timeout", timeout_err, 0);

        // Load with no ack: times out
        run_op(1, 0, 32'h24, 32'h0, -1, 32'h0, stall_n, req_n, we_ok, addr_ok, wdata_ok, rv, done_a);
        check("to_req_cycles", req_n, 5);
        check("to_stall_cycles", stall_n, 6);
        check("to_timeout_err", timeout_err, 1);
        check("to_rd_data", rd_data, 0);
        check("to_rd_valid", rv, 0);

        // Next access completes normally, timeout_err sticky
        run_op(1, 0, 32'h30, 32'h0, 1, 32'hCAFEF00D, stall_n, req_n, we_ok, addr_ok, wdata_ok, rv, done_a);
        check("after_to_stall", stall_n, 3);
        check("after_to_rv", rv, 1);
        check("after_to_data", rd_data, 32'hCAFEF00D);
        check("after_to_sticky", timeout_err, 1);

        // Misaligned load
        run_op(1, 0, 32'h13, 32'h0, 0, 32'h55555555, stall_n, req_n, we_ok, addr_ok, wdata_ok, rv, done_a);
        check("mis_stall", stall_n, 1);
        check("mis_no_req", req_n, 0);
        check("mis_align_err", align_err, 1);
        check("mis_rd_data_kept", rd_data, 32'hCAFEF00D);
        check("mis_rv", rv, 0);

        // Read and write together: write wins
        run_op(1, 1, 32'h40, 32'hA5A5A5A5, 0, 32'h0, stall_n, req_n, we_ok, addr_ok, wdata_ok, rv, done_a);
        check("rw_we_ok", we_ok, 1);
        check("rw_req", req_n, 1);
        check("rw_rv", rv, 0);
        check("rw_align_sticky", align_err, 1);

        // Reset during WAIT
        @(posedge clk); #1;
        MEM_R_EN = 1; ALU_result = 32'h50;
        repeat (3) @(negedge clk);
        check("rst_wait_req", mem_req, 1);
        rst = 1; MEM_R_EN = 0;
        @(negedge clk);
        check("rstw_stall", stall, 0);
        check("rstw_req", mem_req, 0);
        check("rstw_addr", mem_addr, 0);
        check("rstw_flags", {timeout_err, align_err, rd_valid, mem_we}, 0);
        check("rstw_rd_data", rd_data, 0);
        rst = 0; mem_ack = 1; mem_rdata = 32'h77777777;
        @(negedge clk);
        check("late_ack_rv", rd_valid, 0);
        check("late_ack_state", {stall, mem_req}, 0);
        mem_ack = 0;
        @(negedge clk);
        check("late_ack_rd_data", rd_data, 0);

        // Back-to-back loads
        run_op(1, 0, 32'h00, 32'h0, 0, 32'h11111111, stall_n, req_n, we_ok, addr_ok, wdata_ok, rv, done_a);
        check("b2b0_rv", rv, 1);
        check("b2b0_data", rd_data, 32'h11111111);
        run_op(1, 0, 32'h04, 32'h0, 0, 32'h22222222, stall_n, req_n, we_ok, addr_ok, wdata_ok, rv, done_b);
        check("b2b1_rv", rv, 1);
        check("b2b1_data", rd_data, 32'h22222222);
        check("b2b1_addr_ok", addr_ok, 1);
        check("b2b_spacing", done_b - done_a, 3);

        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
